// File: rtl/mult_share_pkg.sv
// Shared constants, pipeline stage record and round-robin pointer helper for mult_share_sched.
package mult_share_pkg;

  localparam int unsigned A_W = 8;
  localparam int unsigned P_W = 16;
  // Widest requester id (NREQ up to 8); narrower instances truncate.
  localparam int unsigned ID_MAXW = 3;

  typedef struct packed {
    logic               v;
    logic [A_W-1:0]     a;
    logic [A_W-1:0]     b;
    logic [ID_MAXW-1:0] id;
  } stage_t;

  // Pointer after granting `grant` among n requesters; an out-of-range grant leaves it unchanged.
  function automatic logic [ID_MAXW-1:0] rr_next(input logic [ID_MAXW-1:0] ptr,
                                                 input logic [ID_MAXW-1:0] grant,
                                                 input int unsigned n);
    if (32'(grant) >= n) return ptr;
    return (32'(grant) == n - 1) ? '0 : grant + ID_MAXW'(1);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or above ptr, wrapping modulo NREQ.
module rr_arbiter #(
  parameter  int unsigned NREQ = 4,
  localparam int unsigned IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] grant_oh,
  output logic [IDW-1:0]  grant_idx,
  output logic            any
);

  int unsigned idx;

  always_comb begin
    grant_oh  = '0;
    grant_idx = '0;
    any       = 1'b0;
    idx       = 0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      idx = (32'(ptr) + k) % NREQ;
      if (!any && req[idx]) begin
        any           = 1'b1;
        grant_idx     = IDW'(idx);
        grant_oh[idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/wallace_mul8.sv
// Exact unsigned 8x8 multiplier: carry-save (Wallace) reduction of partial products, one final add.
module wallace_mul8
  import mult_share_pkg::*;
(
  input  logic [A_W-1:0] a,
  input  logic [A_W-1:0] b,
  output logic [P_W-1:0] p,
  output logic           cout
);

  localparam int unsigned W = P_W + 1;
  typedef logic [W-1:0] word_t;

  // 3:2 compressor over whole words; returns {carry, sum}.
  function automatic logic [2*W-1:0] csa(input word_t x, input word_t y, input word_t z);
    word_t s, c;
    s = x ^ y ^ z;
    c = ((x & y) | (x & z) | (y & z)) << 1;
    return {c, s};
  endfunction

  word_t pp [A_W];
  word_t s0, c0, s1, c1, s2, c2, s3, c3, s4, c4, s5, c5;

  always_comb begin
    for (int unsigned i = 0; i < A_W; i++) begin
      pp[i] = b[i] ? (W'(a) << i) : '0;
    end
    // 8 -> 6 -> 4 -> 3 -> 2 operands
    {c0, s0} = csa(pp[0], pp[1], pp[2]);
    {c1, s1} = csa(pp[3], pp[4], pp[5]);
    {c2, s2} = csa(s0, c0, s1);
    {c3, s3} = csa(c1, pp[6], pp[7]);
    {c4, s4} = csa(s2, c2, s3);
    {c5, s5} = csa(s4, c4, c3);
    {cout, p} = s5 + c5;
  end

endmodule

// File: rtl/mult_share_sched.sv
// Shares one 8x8 multiplier among NREQ requesters: round-robin grant, 2-stage valid/ready pipeline.
module mult_share_sched
  import mult_share_pkg::*;
#(
  parameter  int unsigned NREQ = 4,
  parameter  int unsigned CNTW = 16,
  localparam int unsigned IDW  = $clog2(NREQ)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NREQ-1:0]     req_valid,
  input  logic [8*NREQ-1:0]   req_a,
  input  logic [8*NREQ-1:0]   req_b,
  output logic [NREQ-1:0]     req_ready,
  output logic                rsp_valid,
  output logic [P_W-1:0]      rsp_data,
  output logic [IDW-1:0]      rsp_id,
  input  logic                rsp_ready,
  output logic [CNTW-1:0]     ops_cnt
);

  logic [IDW-1:0]  ptr_q;
  logic [NREQ-1:0] grant_oh;
  logic [IDW-1:0]  grant_idx;
  logic            any;
  logic            s1_adv, s2_adv, accept;
  stage_t          s1_q, s1_d;
  logic [P_W-1:0]  mul_p;
  logic [CNTW-1:0] ops_cnt_q;

  rr_arbiter #(
    .NREQ(NREQ)
  ) u_arb (
    .req      (req_valid),
    .ptr      (ptr_q),
    .grant_oh (grant_oh),
    .grant_idx(grant_idx),
    .any      (any)
  );

  assign s2_adv    = !rsp_valid | rsp_ready;
  assign s1_adv    = !s1_q.v | s2_adv;
  assign accept    = any & s1_adv;
  assign req_ready = accept ? grant_oh : '0;
  assign ops_cnt   = ops_cnt_q;

  always_comb begin
    s1_d = s1_q;
    if (s1_adv) begin
      s1_d.v = accept;
      if (accept) begin
        s1_d.a  = req_a[A_W*grant_idx +: A_W];
        s1_d.b  = req_b[A_W*grant_idx +: A_W];
        s1_d.id = ID_MAXW'(grant_idx);
      end
    end
  end

  // Carry-out is always zero for an exact 8x8 product.
  wallace_mul8 u_mul (
    .a   (s1_q.a),
    .b   (s1_q.b),
    .p   (mul_p),
    .cout()
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q      <= '0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_id    <= '0;
      ptr_q     <= '0;
      ops_cnt_q <= '0;
    end else begin
      s1_q <= s1_d;
      if (s2_adv) begin
        rsp_valid <= s1_q.v;
        if (s1_q.v) begin
          rsp_data <= mul_p;
          rsp_id   <= IDW'(s1_q.id);
        end
      end
      if (accept) begin
        ptr_q <= IDW'(rr_next(ID_MAXW'(ptr_q), ID_MAXW'(grant_idx), NREQ));
      end
      if (rsp_valid && rsp_ready) begin
        ops_cnt_q <= ops_cnt_q + CNTW'(1);
      end
    end
  end

endmodule
